// File: rtl/haar_idwt_if.sv
// haar_idwt_if: coefficient-in / sample-out bus for the inverse Haar stage.
// Handshake rule (both directions): a beat transfers on a rising clk edge where
// valid & ready are both 1; once asserted, valid and its payload hold
// stable until that transfer edge; ready may change freely.
// in_a is the signed approx coeff, in_d the signed detail coeff (one bit wider),
// dout a signed reconstructed sample.
interface haar_idwt_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH:0]   in_d;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_last;
  logic                  done;

  modport master (
    output start, in_a, in_d, in_valid, dout_ready,
    input  in_ready, dout, dout_valid, dout_last, done
  );

  modport slave (
    input  start, in_a, in_d, in_valid, dout_ready,
    output in_ready, dout, dout_valid, dout_last, done
  );
endinterface

// File: rtl/haar_idwt.sv
// haar_idwt: single-level inverse integer Haar (S-transform).
// Each accepted (a, d) pair yields x1 = a - (d >>> 1) and x0 = d + x1, emitted
// x0 then x1; SIGNAL_LENGTH/2 pairs make one frame, closed by a done pulse.
// Build option: define HAAR_IDWT_SAT_EN to saturate x0/x1 to DATA_WIDTH bits;
// otherwise they wrap (two's complement truncation). Timing is identical.
// dbg_state exposes the FSM encoding for observation.
module haar_idwt #(
  parameter int DATA_WIDTH    = 8,
  parameter int SIGNAL_LENGTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  haar_idwt_if.slave   bus,
  output logic [2:0]   dbg_state
);

  localparam int PAIRS = SIGNAL_LENGTH / 2;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int IW    = DATA_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_OUT0   = 3'd2,
    S_OUT1   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         pair_cnt;
  logic [DATA_WIDTH-1:0] x0_q, x1_q;
  logic [DATA_WIDTH-1:0] x0_r, x1_r;
  logic signed [IW-1:0]  a_ext, d_ext, x0_w, x1_w;
  logic                  last_pair;
  logic                  accept;

  assign dbg_state = state_q;
  assign last_pair = (pair_cnt == CW'(PAIRS - 1));
  assign accept    = (state_q == S_ACCEPT) && bus.in_valid;

  // Widen both coefficients so neither x1 nor x0 can overflow before resize.
  assign a_ext = IW'(signed'(bus.in_a));
  assign d_ext = IW'(signed'(bus.in_d));
  assign x1_w  = a_ext - (d_ext >>> 1);
  assign x0_w  = d_ext + x1_w;

`ifdef HAAR_IDWT_SAT_EN
  localparam logic signed [IW-1:0] MAXV = IW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [IW-1:0] MINV = -MAXV - IW'(1);

  // Clamp the wide results into the signed DATA_WIDTH range.
  always_comb begin
    x0_r = x0_w[DATA_WIDTH-1:0];
    x1_r = x1_w[DATA_WIDTH-1:0];
    if (x0_w > MAXV)      x0_r = MAXV[DATA_WIDTH-1:0];
    else if (x0_w < MINV) x0_r = MINV[DATA_WIDTH-1:0];
    if (x1_w > MAXV)      x1_r = MAXV[DATA_WIDTH-1:0];
    else if (x1_w < MINV) x1_r = MINV[DATA_WIDTH-1:0];
  end
`else
  // Wrap: keep the low DATA_WIDTH bits, drop the guard bits.
  logic unused_hi;
  assign x0_r      = x0_w[DATA_WIDTH-1:0];
  assign x1_r      = x1_w[DATA_WIDTH-1:0];
  assign unused_hi = ^{x0_w[IW-1:DATA_WIDTH], x1_w[IW-1:DATA_WIDTH]};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: latch results on accept, track the pair index within the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pair_cnt <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
    end else begin
      if (state_q == S_IDLE && bus.start) pair_cnt <= '0;
      if (accept) begin
        x0_q <= x0_r;
        x1_q <= x1_r;
      end
      if (state_q == S_OUT1 && bus.dout_ready && !last_pair)
        pair_cnt <= pair_cnt + CW'(1);
    end
  end

  // Next state and outputs, all decoded from the registered state.
  always_comb begin
    state_d        = state_q;
    bus.in_ready   = 1'b0;
    bus.dout_valid = 1'b0;
    bus.dout       = '0;
    bus.dout_last  = 1'b0;
    bus.done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = S_OUT0;
      end
      S_OUT0: begin
        bus.dout_valid = 1'b1;
        bus.dout       = x0_q;
        if (bus.dout_ready) state_d = S_OUT1;
      end
      S_OUT1: begin
        bus.dout_valid = 1'b1;
        bus.dout       = x1_q;
        bus.dout_last  = last_pair;
        if (bus.dout_ready) state_d = last_pair ? S_DONE : S_ACCEPT;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_haar_idwt.sv
// tb_haar_idwt: directed bench for haar_idwt (DATA_WIDTH=8, SIGNAL_LENGTH=8).
// Expected samples come from hand evaluation of x1 = a - floor(d/2), x0 = d + x1,
// and for the round-trip frames from a forward S-transform of random samples.
module tb_haar_idwt;

  localparam int DW = 8;
  localparam int SL = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEPT = 3'd1;
  localparam logic [2:0] ST_OUT0   = 3'd2;
  localparam logic [2:0] ST_OUT1   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

`ifdef HAAR_IDWT_SAT_EN
  localparam int OVF_P0_X0 = 127;
  localparam int OVF_P1_X0 = -128;
  localparam int OVF_P2_X1 = 127;
  localparam int OVF_P3_X1 = -128;
`else
  localparam int OVF_P0_X0 = -1;
  localparam int OVF_P1_X0 = 0;
  localparam int OVF_P2_X1 = -1;
  localparam int OVF_P3_X1 = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  dbg_state;
  int          n_vec = 0;
  int          n_err = 0;
  logic [DW-1:0] exp_q[$];

  haar_idwt_if #(.DATA_WIDTH(DW)) bus();

  haar_idwt #(.DATA_WIDTH(DW), .SIGNAL_LENGTH(SL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] exp);
    chk(tag, {13'd0, dbg_state}, {13'd0, exp});
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_dout"},       {8'd0, bus.dout},        16'd0);
    chk({tag, "_dout_valid"}, {15'd0, bus.dout_valid}, 16'd0);
    chk({tag, "_in_ready"},   {15'd0, bus.in_ready},   16'd0);
    chk({tag, "_dout_last"},  {15'd0, bus.dout_last},  16'd0);
    chk({tag, "_done"},       {15'd0, bus.done},       16'd0);
    chk_state({tag, "_state"}, ST_IDLE);
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_state("start_state", ST_ACCEPT);
  endtask

  // Drive one pair, optionally stall x0 for hold0 cycles, optionally pulse start in S_OUT1.
  task automatic send_pair(input int a, input int d, input int e0, input int e1,
                           input bit last, input int hold0, input bit spulse);
    int w;
    bus.in_a       = a[DW-1:0];
    bus.in_d       = d[DW:0];
    bus.in_valid   = 1'b1;
    bus.dout_ready = (hold0 == 0);
    w = 0;
    while (!bus.in_ready && w < 20) begin
      step();
      w++;
    end
    chk("in_ready_wait", {15'd0, bus.in_ready}, 16'd1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < hold0; i++) begin
      chk("hold_dout",     {8'd0, bus.dout},        {8'd0, e0[DW-1:0]});
      chk("hold_valid",    {15'd0, bus.dout_valid}, 16'd1);
      chk("hold_in_ready", {15'd0, bus.in_ready},   16'd0);
      step();
    end
    bus.dout_ready = 1'b1;
    chk("x0",       {8'd0, bus.dout},        {8'd0, e0[DW-1:0]});
    chk("x0_valid", {15'd0, bus.dout_valid}, 16'd1);
    chk("x0_last",  {15'd0, bus.dout_last},  16'd0);
    step();
    chk("x1",       {8'd0, bus.dout},        {8'd0, e1[DW-1:0]});
    chk("x1_valid", {15'd0, bus.dout_valid}, 16'd1);
    chk("x1_last",  {15'd0, bus.dout_last},  {15'd0, last});
    if (spulse) bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("done_after_pair", {15'd0, bus.done}, {15'd0, last});
    chk_state("state_after_pair", last ? ST_DONE : ST_ACCEPT);
  endtask

  // Leave S_DONE; optionally try a start there, which must be ignored.
  task automatic finish_frame(input bit start_in_done);
    if (start_in_done) bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("done_one_cycle", {15'd0, bus.done}, 16'd0);
    chk_state("idle_after_done", ST_IDLE);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_d       = '0;
    bus.dout_ready = 1'b1;

    // Reset values.
    rst_n = 1'b0;
    repeat (3) step();
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    step();
    chk_state("post_reset_idle", ST_IDLE);

    // Reset in the middle of S_OUT0 discards the frame.
    start_frame();
    bus.in_a       = 8'd7;
    bus.in_d       = 9'd6;
    bus.in_valid   = 1'b1;
    bus.dout_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk_state("mid_out0_state", ST_OUT0);
    chk("mid_out0_dout", {8'd0, bus.dout}, 16'd10);
    rst_n = 1'b0;
    step();
    chk_zero_outputs("mid_reset");
    rst_n          = 1'b1;
    bus.dout_ready = 1'b1;
    step();
    chk("no_done_after_reset", {15'd0, bus.done}, 16'd0);
    chk_state("idle_after_reset", ST_IDLE);

    // Basic frame: (7,6)->10,4 (-1,-5)->-3,2 (0,0)->0,0 (5,1)->6,5.
    start_frame();
    send_pair(7, 6, 10, 4, 1'b0, 0, 1'b0);
    send_pair(-1, -5, -3, 2, 1'b0, 0, 1'b0);
    send_pair(0, 0, 0, 0, 1'b0, 0, 1'b0);
    send_pair(5, 1, 6, 5, 1'b1, 0, 1'b0);
    finish_frame(1'b0);

    // Backpressure on x0 for 5 cycles; start during S_DONE is ignored.
    start_frame();
    send_pair(7, 6, 10, 4, 1'b0, 5, 1'b0);
    send_pair(-1, -5, -3, 2, 1'b0, 0, 1'b0);
    send_pair(0, 0, 0, 0, 1'b0, 0, 1'b0);
    send_pair(5, 1, 6, 5, 1'b1, 0, 1'b0);
    finish_frame(1'b1);

    // Range extremes: x0/x1 resize by wrap or saturation.
    start_frame();
    send_pair(127, 255, OVF_P0_X0, 0, 1'b0, 0, 1'b0);
    send_pair(-128, -256, OVF_P1_X0, 0, 1'b0, 0, 1'b0);
    send_pair(127, -256, -1, OVF_P2_X1, 1'b0, 0, 1'b0);
    send_pair(-128, 255, 0, OVF_P3_X1, 1'b1, 0, 1'b0);
    finish_frame(1'b0);

    // Protocol: in_valid while idle is not consumed; start in S_OUT1 is ignored.
    bus.in_a     = 8'd3;
    bus.in_d     = 9'd2;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_in_ready", {15'd0, bus.in_ready}, 16'd0);
      chk_state("idle_hold", ST_IDLE);
    end
    start_frame();
    send_pair(3, 2, 4, 2, 1'b0, 0, 1'b1);
    send_pair(-2, 3, 0, -3, 1'b0, 0, 1'b0);
    send_pair(10, -7, 7, 14, 1'b0, 0, 1'b0);
    send_pair(-50, 100, 0, -100, 1'b1, 0, 1'b0);
    finish_frame(1'b0);

    // Round trip: random samples through the forward S-transform.
    for (int f = 0; f < 2; f++) begin
      start_frame();
      for (int p = 0; p < SL / 2; p++) begin
        int x0, x1, d, a;
        logic [DW-1:0] e0, e1;
        x0 = int'($urandom_range(0, 255)) - 128;
        x1 = int'($urandom_range(0, 255)) - 128;
        d  = x0 - x1;
        a  = x1 + (d >>> 1);
        exp_q.push_back(x0[DW-1:0]);
        exp_q.push_back(x1[DW-1:0]);
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        send_pair(a, d, int'(e0), int'(e1), (p == SL / 2 - 1), 0, 1'b0);
      end
      finish_frame(1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
